// File: rtl/alu_md_controller_pkg.sv
// Shared encodings for the EX-stage ALU controller: ALU op codes,
// RV32M funct3/funct7 values and the multiply/divide sequencer states.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0011,
    ALU_SLL = 4'b0100,
    ALU_SRL = 4'b0101,
    ALU_XOR = 4'b0110,
    ALU_SRA = 4'b0111,
    ALU_EQ  = 4'b1000,
    ALU_SLT = 4'b1100
  } alu_op_t;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_t;

endpackage

// File: rtl/alu_md_controller_md_iter_unit.sv
// Iterative RV32M datapath: one bit per step of shift-add multiply or
// restoring divide on operand magnitudes, with sign fix-up and special cases.
import alu_pkg::*;

module md_iter_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            step,
  input  logic            finish,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] srca,
  input  logic [XLEN-1:0] srcb,
  output logic            special,
  output logic [XLEN-1:0] result
);

  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic [XLEN-1:0] hi, lo, opb;
  logic [2:0]      op;
  logic            neg_q, neg_r;

  logic            sgn_a, sgn_b, div_zero, ovf;
  logic [XLEN-1:0] mag_a, mag_b, spec_res;
  logic [XLEN:0]   mul_sum, div_trial;
  logic [XLEN-1:0] hi_n, lo_n, mulh_val, fixed;

  always_comb begin
    sgn_a    = srca[XLEN-1] & (funct3 == MD_MULH || funct3 == MD_MULHSU ||
                               funct3 == MD_DIV  || funct3 == MD_REM);
    sgn_b    = srcb[XLEN-1] & (funct3 == MD_MULH || funct3 == MD_DIV ||
                               funct3 == MD_REM);
    mag_a    = sgn_a ? -srca : srca;
    mag_b    = sgn_b ? -srcb : srcb;
    div_zero = funct3[2] && (srcb == '0);
    ovf      = (funct3 == MD_DIV || funct3 == MD_REM) &&
               (srca == MOST_NEG) && (srcb == '1);
    special  = div_zero | ovf;
    // funct3[1] separates REM/REMU from DIV/DIVU
    if (div_zero) spec_res = funct3[1] ? srca : '1;
    else          spec_res = funct3[1] ? '0   : srca;
  end

  always_comb begin
    mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, opb} : '0);
    div_trial = {hi, lo[XLEN-1]} - {1'b0, opb};
    if (op[2]) begin
      hi_n = div_trial[XLEN] ? {hi[XLEN-2:0], lo[XLEN-1]} : div_trial[XLEN-1:0];
      lo_n = {lo[XLEN-2:0], ~div_trial[XLEN]};
    end else begin
      hi_n = mul_sum[XLEN:1];
      lo_n = {mul_sum[0], lo[XLEN-1:1]};
    end
    // Upper half of -{hi,lo}: the +1 only carries into hi when lo is zero
    mulh_val = neg_q ? (~hi_n + XLEN'(lo_n == '0)) : hi_n;
    case (op)
      MD_MUL:                       fixed = lo_n;
      MD_MULH, MD_MULHSU, MD_MULHU: fixed = mulh_val;
      MD_DIV, MD_DIVU:              fixed = neg_q ? -lo_n : lo_n;
      default:                      fixed = neg_r ? -hi_n : hi_n;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi     <= '0;
      lo     <= '0;
      opb    <= '0;
      op     <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      result <= '0;
    end else if (load) begin
      hi    <= '0;
      lo    <= mag_a;
      opb   <= mag_b;
      op    <= funct3;
      neg_q <= sgn_a ^ sgn_b;
      neg_r <= sgn_a;
      if (special) result <= spec_res;
    end else if (step) begin
      hi <= hi_n;
      lo <= lo_n;
      if (finish) result <= fixed;
    end
  end

endmodule

// File: rtl/alu_md_controller.sv
// EX-stage ALU controller for RV32IM: ALU op decode plus the sequencer that
// stalls the pipeline while an iterative multiply/divide runs.
import alu_pkg::*;

module alu_md_controller #(
  parameter int unsigned XLEN = 32,
  parameter bit          EN_M = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [1:0]      ALUOp,
  input  logic            RType,
  input  logic [6:0]      Funct7,
  input  logic [2:0]      Funct3,
  input  logic            issue,
  input  logic            flush,
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  output logic [3:0]      Operation,
  output logic            md_sel,
  output logic            stall,
  output logic [XLEN-1:0] md_result,
  output logic            md_done
);

  localparam int unsigned CW = $clog2(XLEN);

  alu_op_t   op;
  logic      is_md, start, load, step, finish, md_special;
  md_state_t state, state_n;
  logic [CW-1:0] cnt;

  always_comb begin
    is_md = EN_M && (ALUOp == 2'b10) && RType && (Funct7 == F7_MULDIV);
    op    = ALU_AND;
    case (ALUOp)
      2'b00, 2'b11: op = ALU_ADD;
      2'b01:        op = ALU_EQ;
      default: begin
        if (is_md) op = ALU_ADD;
        else begin
          case (Funct3)
            3'b000:  op = (RType && Funct7 == F7_ALT) ? ALU_SUB : ALU_ADD;
            3'b111:  op = ALU_AND;
            3'b110:  op = ALU_OR;
            3'b100:  op = ALU_XOR;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b101: begin
              if (Funct7 == F7_BASE)     op = ALU_SRL;
              else if (Funct7 == F7_ALT) op = ALU_SRA;
              else                       op = ALU_AND;
            end
            default: op = ALU_AND;
          endcase
        end
      end
    endcase
  end

  assign Operation = op;
  assign md_sel    = is_md;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= MD_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      if (load)      cnt <= '0;
      else if (step) cnt <= cnt + 1'b1;
    end
  end

  // reset gates start so stall falls the instant reset asserts
  assign start = issue & is_md & ~flush & ~reset;

  always_comb begin
    state_n = state;
    stall   = 1'b0;
    load    = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    md_done = 1'b0;
    case (state)
      MD_IDLE: begin
        if (start) begin
          load    = 1'b1;
          stall   = 1'b1;
          state_n = md_special ? MD_DONE : MD_BUSY;
        end
      end
      MD_BUSY: begin
        if (flush) state_n = MD_IDLE;
        else begin
          stall = ~reset;
          step  = 1'b1;
          if (cnt == CW'(XLEN-1)) begin
            finish  = 1'b1;
            state_n = MD_DONE;
          end
        end
      end
      MD_DONE: begin
        md_done = ~flush;
        state_n = MD_IDLE;
      end
      default: state_n = MD_IDLE;
    endcase
  end

  generate
    if (EN_M) begin : g_md
      md_iter_unit #(.XLEN(XLEN)) u_md (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .step    (step),
        .finish  (finish),
        .funct3  (Funct3),
        .srca    (SrcA),
        .srcb    (SrcB),
        .special (md_special),
        .result  (md_result)
      );
    end else begin : g_no_md
      assign md_special = 1'b0;
      assign md_result  = '0;
    end
  endgenerate

endmodule

// File: tb/tb_alu_md_controller.sv
// Directed self-checking bench for alu_md_controller (XLEN=32, M enabled).
module tb_alu_md_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  ALUOp;
  logic        RType;
  logic [6:0]  Funct7;
  logic [2:0]  Funct3;
  logic        issue, flush;
  logic [31:0] SrcA, SrcB;
  logic [3:0]  Operation;
  logic        md_sel, stall, md_done;
  logic [31:0] md_result;

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  alu_md_controller #(.XLEN(32), .EN_M(1'b1)) dut (
    .clk(clk), .reset(reset), .ALUOp(ALUOp), .RType(RType), .Funct7(Funct7),
    .Funct3(Funct3), .issue(issue), .flush(flush), .SrcA(SrcA), .SrcB(SrcB),
    .Operation(Operation), .md_sel(md_sel), .stall(stall),
    .md_result(md_result), .md_done(md_done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic dec(input string tag, input logic [1:0] aop, input logic rt,
                     input logic [6:0] f7, input logic [2:0] f3, input logic [3:0] exp_op);
    ALUOp = aop; RType = rt; Funct7 = f7; Funct3 = f3; issue = 1'b1;
    #1;
    chk({tag, " op"}, {28'd0, Operation}, {28'd0, exp_op});
    chk({tag, " stall"}, {31'd0, stall}, 32'd0);
  endtask

  task automatic run_md(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] res, input int lat);
    int cyc;
    logic stall_ok;
    ALUOp = 2'b10; RType = 1'b1; Funct7 = 7'b0000001; Funct3 = f3;
    SrcA = a; SrcB = b; issue = 1'b1;
    #1;
    chk({tag, " stall0"}, {31'd0, stall}, 32'd1);
    chk({tag, " md_sel"}, {31'd0, md_sel}, 32'd1);
    stall_ok = 1'b1;
    cyc = 0;
    while (cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (md_done) break;
      if (!stall) stall_ok = 1'b0;
    end
    chk({tag, " latency"}, cyc, lat);
    chk({tag, " result"}, md_result, res);
    chk({tag, " stall@done"}, {31'd0, stall}, 32'd0);
    chk({tag, " stall held"}, {31'd0, stall_ok}, 32'd1);
    issue = 1'b0;
    @(posedge clk); #1;
    chk({tag, " done pulse"}, {31'd0, md_done}, 32'd0);
  endtask

  initial begin
    logic no_done;
    reset = 1'b1; issue = 1'b0; flush = 1'b0;
    ALUOp = 2'b00; RType = 1'b0; Funct7 = '0; Funct3 = '0; SrcA = '0; SrcB = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset md_result", md_result, 32'd0);
    chk("reset md_done", {31'd0, md_done}, 32'd0);
    chk("reset stall", {31'd0, stall}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    dec("sub",     2'b10, 1'b1, 7'b0100000, 3'b000, 4'b0011);
    dec("addi",    2'b10, 1'b0, 7'b0100000, 3'b000, 4'b0010);
    dec("sra",     2'b10, 1'b1, 7'b0100000, 3'b101, 4'b0111);
    dec("srl",     2'b10, 1'b1, 7'b0000000, 3'b101, 4'b0101);
    dec("beq",     2'b01, 1'b0, 7'b0000000, 3'b000, 4'b1000);
    dec("and",     2'b10, 1'b1, 7'b0000000, 3'b111, 4'b0000);
    dec("slt",     2'b10, 1'b1, 7'b0000000, 3'b010, 4'b1100);
    dec("xor",     2'b10, 1'b1, 7'b0000000, 3'b100, 4'b0110);
    dec("lui",     2'b11, 1'b0, 7'b0000000, 3'b000, 4'b0010);
    dec("ld m7",   2'b00, 1'b1, 7'b0000001, 3'b100, 4'b0010);
    chk("ld m7 md_sel", {31'd0, md_sel}, 32'd0);
    issue = 1'b0;
    @(posedge clk); #1;

    run_md("MUL",      3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33);
    run_md("MULHU",    3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
    run_md("MULH",     3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33);
    run_md("MULHSU",   3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33);
    run_md("MULHU big",3'b011, 32'h80000000, 32'd4,        32'h00000002, 33);
    run_md("DIV 5/0",  3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
    run_md("REM 5/0",  3'b110, 32'd5,        32'd0,        32'd5,        1);
    run_md("DIV ovf",  3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run_md("REM ovf",  3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1);
    run_md("DIV -7/2", 3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33);
    run_md("REM -7/2", 3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33);
    run_md("DIVU",     3'b101, 32'hFFFFFFF9, 32'd2,        32'h7FFFFFFC, 33);
    run_md("DIVU nov", 3'b101, 32'h80000000, 32'hFFFFFFFF, 32'd0,        33);
    run_md("REMU",     3'b111, 32'd100,      32'd7,        32'd2,        33);
    run_md("DIVU /0",  3'b101, 32'd9,        32'd0,        32'hFFFFFFFF, 1);
    run_md("REMU /0",  3'b111, 32'h1234,     32'd0,        32'h1234,     1);

    // flush during BUSY cycle 10
    ALUOp = 2'b10; RType = 1'b1; Funct7 = 7'b0000001; Funct3 = 3'b000;
    SrcA = 32'd3; SrcB = 32'd9; issue = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    chk("flush pre stall", {31'd0, stall}, 32'd1);
    flush = 1'b1; issue = 1'b0;
    @(posedge clk); #1;
    flush = 1'b0;
    #1;
    chk("flush stall", {31'd0, stall}, 32'd0);
    chk("flush md_done", {31'd0, md_done}, 32'd0);
    chk("flush hold", md_result, 32'h1234);
    no_done = 1'b1;
    repeat (40) begin @(posedge clk); #1; if (md_done) no_done = 1'b0; end
    chk("flush no done", {31'd0, no_done}, 32'd1);
    chk("flush hold late", md_result, 32'h1234);

    // asynchronous reset in the middle of BUSY
    Funct3 = 3'b000; SrcA = 32'd3; SrcB = 32'd9; issue = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    chk("rst pre stall", {31'd0, stall}, 32'd1);
    reset = 1'b1;
    #1;
    chk("rst stall", {31'd0, stall}, 32'd0);
    chk("rst md_result", md_result, 32'd0);
    chk("rst md_done", {31'd0, md_done}, 32'd0);
    issue = 1'b0;
    #2;
    reset = 1'b0;
    @(posedge clk); #1;
    run_md("MUL post", 3'b000, 32'd6, 32'd7, 32'd42, 33);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
